// File: rtl/bram_stream_mover.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_mover
// Desc     : Moves a block of words between a ready/valid stream and one
//            BRAM port. LOAD writes the input stream into BRAM, DUMP reads
//            BRAM through a 2-entry FIFO onto the output stream.
// Revision : 1.0 - initial release
// ============================================================================
module bram_stream_mover #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   num_words,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [AWIDTH-1:0] bram_addr,
  output logic              bram_ce,
  output logic              bram_we,
  output logic [DWIDTH-1:0] bram_d,
  input  logic [DWIDTH-1:0] bram_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AWIDTH:0]   c_CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] c_ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH-1:0]   r_addr;      // current BRAM address, wraps naturally
  logic [AWIDTH:0]     r_len;       // latched transfer length
  logic [AWIDTH:0]     r_cnt;       // words written (LOAD) or reads issued (DUMP)
  logic [AWIDTH:0]     r_pop_cnt;   // words popped from the output FIFO
  logic [DWIDTH-1:0]   r_fifo [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_occ;
  logic                r_inflight;  // a read was issued last cycle; bram_q is valid now
  logic                w_start;
  logic                w_wr;
  logic                w_rd;
  logic                w_pop;
  logic [2:0]          w_credit;

  assign w_start   = (r_state == S_IDLE) && start;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign s_ready   = (r_state == S_LOAD) && (r_cnt < r_len);
  assign w_wr      = s_valid && s_ready;
  assign m_valid   = (r_occ != 2'd0);
  assign w_pop     = m_valid && m_ready;
  // FIFO slots already committed: stored words plus the read landing now,
  // minus the word leaving this cycle. Counting the pop lets the read
  // pipeline run back-to-back when the consumer never stalls.
  assign w_credit  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd      = (r_state == S_DUMP) && (w_credit < 3'd2) && (r_cnt < r_len);
  assign bram_ce   = w_wr || w_rd;
  assign bram_we   = w_wr;
  assign bram_addr = r_addr;
  assign bram_d    = w_wr ? s_data : '0;
  assign m_data    = m_valid ? r_fifo[r_rd_ptr] : '0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode: a zero-length command skips straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) w_state_nxt = S_DONE;
          else if (mode)       w_state_nxt = S_DUMP;
          else                 w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: if (w_wr && (r_cnt == r_len - c_CNT_ONE))      w_state_nxt = S_DONE;
      S_DUMP: if (w_pop && (r_pop_cnt == r_len - c_CNT_ONE)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, address walk and transfer counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_pop_cnt <= '0;
    end else if (w_start) begin
      r_addr    <= base_addr;
      r_len     <= num_words;
      r_cnt     <= '0;
      r_pop_cnt <= '0;
    end else begin
      if (bram_ce) begin
        r_addr <= r_addr + c_ADDR_ONE;
        r_cnt  <= r_cnt + c_CNT_ONE;
      end
      if (w_pop) r_pop_cnt <= r_pop_cnt + c_CNT_ONE;
    end
  end

  // Read pipeline tracking and FIFO pointers/occupancy; reset drops everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_inflight <= w_rd;
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
      case ({r_inflight, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // FIFO storage captures the registered BRAM output one cycle after the read
  always_ff @(posedge clk) begin
    if (r_inflight) r_fifo[r_wr_ptr] <= bram_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_stream_mover
// Desc     : Directed bench for bram_stream_mover with a BRAM model, a
//            reference memory image and queue-based expected traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_stream_mover;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NW = AW + 1;

  logic          clk = 1'b0;
  logic          reset_n, start, mode, s_valid, m_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [DW-1:0] s_data;
  logic [DW-1:0] bram_q;
  logic          busy, done, s_ready, m_valid, bram_ce, bram_we;
  logic [DW-1:0] m_data, bram_d;
  logic [AW-1:0] bram_addr;

  always #5 clk = ~clk;

  bram_stream_mover #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .bram_addr(bram_addr), .bram_ce(bram_ce), .bram_we(bram_we),
    .bram_d(bram_d), .bram_q(bram_q)
  );

  // Single-port BRAM with registered read data
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_we) mem[bram_addr] <= bram_d;
      else         bram_q <= mem[bram_addr];
    end
  end

  // Reference model: memory image and expected traffic in order
  logic [DW-1:0] ref_mem [0:4095];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  logic [DW-1:0] exp_m[$];
  int            wr_cyc_q[$];
  logic [AW-1:0] wr_addr_q[$];
  int            pop_cyc_q[$];
  logic [DW-1:0] pop_data_q[$];

  int total = 0;
  int bad   = 0;
  int sample = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
  int ce_seen = 0, sready_seen = 0, mvalid_seen = 0;
  bit cmd = 1'b0;
  bit stall_pend = 1'b0;
  logic [DW-1:0] stall_data;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_pend = 1'b0;
    end else begin
      sample++;
      if (cmd && start) start_cyc = sample;
      if (bram_ce) ce_seen++;
      if (s_ready) sready_seen++;
      if (m_valid) mvalid_seen++;
      if (bram_ce && bram_we) begin
        wr_cyc_q.push_back(sample);
        wr_addr_q.push_back(bram_addr);
        if (exp_wa.size() == 0) begin
          check(1'b0, "unexpected_write", bram_addr, 0);
        end else begin
          ea = exp_wa.pop_front();
          ed = exp_wd.pop_front();
          check(bram_addr === ea, "wr_addr", bram_addr, ea);
          check(bram_d === ed, "wr_data", bram_d, ed);
        end
      end
      if (stall_pend)
        check(m_valid === 1'b1 && m_data === stall_data, "stall_hold", m_data, stall_data);
      stall_pend = m_valid && !m_ready;
      stall_data = m_data;
      if (m_valid && m_ready) begin
        pop_cyc_q.push_back(sample);
        pop_data_q.push_back(m_data);
        if (exp_m.size() == 0) begin
          check(1'b0, "unexpected_pop", m_data, 0);
        end else begin
          ed = exp_m.pop_front();
          check(m_data === ed, "pop_data", m_data, ed);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = sample;
        check(busy === 1'b1, "busy_in_done", busy, 1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({busy, done, s_ready, m_valid, bram_ce, bram_we} === 6'b0,
          {tag, "_ctrl"}, {busy, done, s_ready, m_valid, bram_ce, bram_we}, 0);
    check(bram_addr === '0, {tag, "_addr"}, bram_addr, 0);
    check(bram_d === '0, {tag, "_bram_d"}, bram_d, 0);
    check(m_data === '0, {tag, "_m_data"}, m_data, 0);
  endtask

  task automatic go(input bit md, input logic [AW-1:0] base, input logic [AW:0] n, input bit rel);
    @(posedge clk); #1;
    if (rel) reset_n = 1'b1;
    start = 1'b1; mode = md; base_addr = base; num_words = n; cmd = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cmd = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] base, input int n, input logic [DW-1:0] d0, input bit rel);
    int idx;
    int d_before;
    bit fin;
    idx = 0; fin = 1'b0;
    wr_cyc_q.delete(); wr_addr_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_wa.push_back(base + AW'(i));
      exp_wd.push_back(d0 + DW'(i));
      ref_mem[base + AW'(i)] = d0 + DW'(i);
    end
    s_valid = 1'b1; s_data = d0;
    d_before = done_cnt;
    go(1'b0, base, NW'(n), rel);
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk); #1;
      if (s_valid && s_ready) idx++;
      if (done) fin = 1'b1;
      @(posedge clk); #1;
      s_data = d0 + DW'(idx);
    end
    s_valid = 1'b0;
    check(fin, "load_done_seen", fin, 1);
    check(exp_wa.size() == 0, "load_all_written", exp_wa.size(), 0);
    check(wr_cyc_q.size() > 0 && wr_cyc_q[0] == start_cyc + 1, "load_first_write", wr_cyc_q[0], start_cyc + 1);
    check(wr_cyc_q.size() > 0 && done_cyc == wr_cyc_q[$] + 1, "load_done_timing", done_cyc, wr_cyc_q[$] + 1);
    @(negedge clk); #1;
    check(done_cnt - d_before == 1, "load_one_done", done_cnt - d_before, 1);
    check(busy === 1'b0, "load_back_idle", busy, 0);
  endtask

  // pat=1 gives m_ready 1,0,0,1,0,0...; abort_after>0 returns right after that pop
  task automatic do_dump(input logic [AW-1:0] base, input int n, input bit pat, input int abort_after);
    int k, pops, d_before;
    bit fin;
    k = 0; pops = 0; fin = 1'b0;
    pop_cyc_q.delete(); pop_data_q.delete();
    for (int i = 0; i < n; i++) exp_m.push_back(ref_mem[base + AW'(i)]);
    m_ready = 1'b1;
    d_before = done_cnt;
    go(1'b1, base, NW'(n), 1'b0);
    m_ready = pat ? (k % 3 == 0) : 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_ready) pops++;
      if (done) fin = 1'b1;
      if (abort_after > 0 && pops == abort_after) fin = 1'b1;
      if (!fin || done) begin
        @(posedge clk); #1;
        k++;
        m_ready = pat ? (k % 3 == 0) : 1'b1;
        if (pat) begin
          start = (k == 4);
          mode  = (k != 4);
        end
      end
    end
    start = 1'b0;
    check(fin, "dump_finished", fin, 1);
    if (abort_after == 0) begin
      check(exp_m.size() == 0, "dump_all_popped", exp_m.size(), 0);
      check(pops == n, "dump_pop_count", pops, n);
      check(pop_cyc_q.size() > 0 && done_cyc == pop_cyc_q[$] + 1, "dump_done_timing", done_cyc, pop_cyc_q[$] + 1);
      @(negedge clk); #1;
      check(done_cnt - d_before == 1, "dump_one_done", done_cnt - d_before, 1);
      check(busy === 1'b0, "dump_back_idle", busy, 0);
    end
  endtask

  initial begin
    int ce0, sr0, mv0, dn0;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; num_words = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    #21 reset_n = 1'b1;

    // LOAD 4 words at 0x010
    do_load(12'h010, 4, 32'hA0, 1'b0);
    check(wr_addr_q[0] === 12'h010, "t1_addr0", wr_addr_q[0], 12'h010);
    check(wr_addr_q[3] === 12'h013, "t1_addr3", wr_addr_q[3], 12'h013);
    check(wr_cyc_q[3] == wr_cyc_q[0] + 3, "t1_consecutive", wr_cyc_q[3] - wr_cyc_q[0], 3);

    // DUMP the same words, consumer always ready
    do_dump(12'h010, 4, 1'b0, 0);
    check(pop_cyc_q[0] == start_cyc + 3, "t2_first_word", pop_cyc_q[0] - start_cyc, 3);
    check(pop_cyc_q[3] == pop_cyc_q[0] + 3, "t2_back_to_back", pop_cyc_q[3] - pop_cyc_q[0], 3);
    check(pop_data_q[0] === 32'hA0, "t2_word0", pop_data_q[0], 32'hA0);
    check(pop_data_q[3] === 32'hA3, "t2_word3", pop_data_q[3], 32'hA3);

    // DUMP of 6 with a stalling consumer and a start pulse while busy
    do_load(12'h020, 6, 32'hC0, 1'b0);
    do_dump(12'h020, 6, 1'b1, 0);
    check(pop_data_q[5] === 32'hC5, "t3_last_word", pop_data_q[5], 32'hC5);

    // Address wrap at the top of the BRAM
    do_load(12'hFFE, 4, 32'hB0, 1'b0);
    check(wr_addr_q[1] === 12'hFFF, "t4_addr1", wr_addr_q[1], 12'hFFF);
    check(wr_addr_q[2] === 12'h000, "t4_addr2", wr_addr_q[2], 12'h000);
    check(wr_addr_q[3] === 12'h001, "t4_addr3", wr_addr_q[3], 12'h001);
    do_dump(12'hFFE, 4, 1'b0, 0);
    check(pop_data_q[2] === 32'hB2, "t4_wrap_read", pop_data_q[2], 32'hB2);

    // Zero-length command
    ce0 = ce_seen; sr0 = sready_seen; mv0 = mvalid_seen; dn0 = done_cnt;
    go(1'b1, 12'h040, '0, 1'b0);
    @(negedge clk); #1;
    check(done === 1'b1, "t5_done_high", done, 1);
    @(negedge clk); #1;
    check(done === 1'b0 && busy === 1'b0, "t5_idle_again", {done, busy}, 0);
    check(done_cyc == start_cyc + 1, "t5_done_timing", done_cyc - start_cyc, 1);
    check(done_cnt - dn0 == 1, "t5_one_done", done_cnt - dn0, 1);
    check(ce_seen == ce0, "t5_no_bram", ce_seen - ce0, 0);
    check(sready_seen == sr0 && mvalid_seen == mv0, "t5_no_stream", (sready_seen - sr0) + (mvalid_seen - mv0), 0);

    // Reset in the middle of a 5-word DUMP, then a fresh LOAD and read-back
    do_dump(12'h020, 5, 1'b0, 2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_m.delete(); exp_wa.delete(); exp_wd.delete();
    m_ready = 1'b1;
    @(posedge clk); #1;
    do_load(12'h100, 3, 32'hD0, 1'b1);
    do_dump(12'h100, 3, 1'b0, 0);
    check(pop_data_q[1] === 32'hD1, "t6_readback", pop_data_q[1], 32'hD1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
